// File: rtl/uart_rx_fsm_if.sv
// Handshake bundle between the UART receive frame controller and the
// per-bit helper blocks (sampler, start/parity/stop checkers, deserializer).
// The controller is the slave side: it consumes line/checker results and
// produces counters, enables and frame-status pulses.
interface uart_rx_fsm_if #(
    parameter int Prescale_width = 6
);
    logic                      rx_in;
    logic [Prescale_width-1:0] Prescale;
    logic                      par_en;
    logic                      strt_glitch;
    logic                      par_err;
    logic                      stp_err;

    logic [Prescale_width-1:0] edge_cnt;
    logic [3:0]                bit_cnt;
    logic                      dat_samp_en;
    logic                      strt_chk_en;
    logic                      deser_en;
    logic                      par_chk_en;
    logic                      stp_chk_en;
    logic                      data_valid;
    logic                      frame_err;
    logic                      busy;

    modport master (
        output rx_in, Prescale, par_en, strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
               par_chk_en, stp_chk_en, data_valid, frame_err, busy
    );

    modport slave (
        input  rx_in, Prescale, par_en, strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
               par_chk_en, stp_chk_en, data_valid, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller. Waits for the start edge, walks the frame
// through START, DATA, optional PARITY and STOP one oversampled bit at a time,
// and reports each frame with a single data_valid or frame_err pulse.
module uart_rx_fsm #(
    parameter int Prescale_width = 6,
    parameter int Data_width     = 8
) (
    input logic          clk,
    input logic          reset,
    uart_rx_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Shorter bit periods leave no room for mid-bit sampling, so they are raised.
    localparam logic [Prescale_width-1:0] MIN_PRESCALE = Prescale_width'(4);
    localparam logic [3:0]                LAST_BIT     = 4'(Data_width - 1);

    state_t                    state_reg, state_next;
    logic [Prescale_width-1:0] edge_cnt_reg, edge_cnt_next;
    logic [3:0]                bit_cnt_reg, bit_cnt_next;
    logic [Prescale_width-1:0] prescale_l_reg, prescale_l_next;
    logic                      par_err_l_reg, par_err_l_next;
    logic                      data_valid_reg, data_valid_next;
    logic                      frame_err_reg, frame_err_next;

    logic [Prescale_width-1:0] prescale_clamped;
    logic [Prescale_width-1:0] last_edge;
    logic                      eob;
    logic                      deser_en_c;

    assign prescale_clamped = (bus.Prescale < MIN_PRESCALE) ? MIN_PRESCALE : bus.Prescale;
    assign last_edge        = prescale_l_reg - Prescale_width'(1);
    assign eob              = (edge_cnt_reg == last_edge);

    // State, counters, latches and status pulses are all registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            edge_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            prescale_l_reg <= '0;
            par_err_l_reg  <= 1'b0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            edge_cnt_reg   <= edge_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            prescale_l_reg <= prescale_l_next;
            par_err_l_reg  <= par_err_l_next;
            data_valid_reg <= data_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // Next-state, counter updates and the end-of-bit deserializer strobe.
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        prescale_l_next = prescale_l_reg;
        par_err_l_next  = par_err_l_reg;
        data_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        deser_en_c      = 1'b0;

        // Free-running within a frame; every state boundary lands on a wrap.
        if (state_reg == IDLE || eob) begin
            edge_cnt_next = '0;
        end else begin
            edge_cnt_next = edge_cnt_reg + Prescale_width'(1);
        end

        case (state_reg)
            IDLE: begin
                if (!bus.rx_in) begin
                    state_next      = START;
                    prescale_l_next = prescale_clamped;
                    par_err_l_next  = 1'b0;
                end
            end
            START: begin
                if (eob) begin
                    if (bus.strt_glitch) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
            end
            DATA: begin
                if (eob) begin
                    deser_en_c = 1'b1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_next = '0;
                        state_next   = bus.par_en ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (eob) begin
                    par_err_l_next = bus.par_err;
                    state_next     = STOP;
                end
            end
            STOP: begin
                if (eob) begin
                    state_next = IDLE;
                    if (bus.stp_err || par_err_l_reg) begin
                        frame_err_next = 1'b1;
                    end else begin
                        data_valid_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Enables come straight from the registered state so they never glitch.
    assign bus.edge_cnt    = edge_cnt_reg;
    assign bus.bit_cnt     = bit_cnt_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.dat_samp_en = (state_reg != IDLE);
    assign bus.strt_chk_en = (state_reg == START);
    assign bus.par_chk_en  = (state_reg == PARITY);
    assign bus.stp_chk_en  = (state_reg == STOP);
    assign bus.deser_en    = deser_en_c;
    assign bus.data_valid  = data_valid_reg;
    assign bus.frame_err   = frame_err_reg;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: a table of whole-frame scenarios with
// hand-computed cycle positions, plus a reset-abort / back-to-back sequence.
module tb_uart_rx_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fsm_if #(.Prescale_width(6)) bus ();

    uart_rx_fsm #(.Prescale_width(6), .Data_width(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int prescale;
        int mid_prescale;
        bit par_en;
        bit glitch;
        bit perr;
        bit serr;
        int exp_end;
        int exp_dv;
        int exp_fe;
        int exp_deser;
        bit exp_parchk;
        int exp_max_edge;
        int exp_max_bit;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outputs();
        return int'({bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.strt_chk_en,
                     bus.deser_en, bus.par_chk_en, bus.stp_chk_en,
                     bus.data_valid, bus.frame_err, bus.busy});
    endfunction

    initial begin
        int dv, fe, dvn, fen, deser, pc, maxe, maxb, endc, both;
        int d1, d2, found;

        // prescale, mid, par_en, glitch, perr, serr, end, dv, fe, deser, parchk, max_edge, max_bit
        vecs[0] = '{8,  8,  1'b1, 1'b0, 1'b0, 1'b0, 89,  89,  0,  8, 1'b1, 7,  7};
        vecs[1] = '{8,  8,  1'b1, 1'b1, 1'b0, 1'b0, 9,   0,   0,  0, 1'b0, 7,  0};
        vecs[2] = '{8,  8,  1'b0, 1'b0, 1'b0, 1'b0, 81,  81,  0,  8, 1'b0, 7,  7};
        vecs[3] = '{8,  8,  1'b1, 1'b0, 1'b1, 1'b0, 89,  0,   89, 8, 1'b1, 7,  7};
        vecs[4] = '{8,  8,  1'b1, 1'b0, 1'b0, 1'b1, 89,  0,   89, 8, 1'b1, 7,  7};
        vecs[5] = '{16, 8,  1'b1, 1'b0, 1'b0, 1'b0, 177, 177, 0,  8, 1'b1, 15, 7};
        vecs[6] = '{2,  2,  1'b0, 1'b0, 1'b0, 1'b0, 41,  41,  0,  8, 1'b0, 3,  7};
        vecs[7] = '{8,  8,  1'b0, 1'b0, 1'b1, 1'b0, 81,  81,  0,  8, 1'b0, 7,  7};

        bus.rx_in       = 1'b1;
        bus.Prescale    = 6'd8;
        bus.par_en      = 1'b0;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;

        // Reset state, during and just after reset.
        @(negedge clk);
        @(negedge clk);
        check_int("reset_outputs", all_outputs(), 0);
        reset = 1'b0;
        @(negedge clk);
        check_int("idle_after_reset", all_outputs(), 0);
        $display("reset: outputs=%0h", all_outputs());

        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            bus.Prescale    = 6'(vecs[v].prescale);
            bus.par_en      = vecs[v].par_en;
            bus.strt_glitch = vecs[v].glitch;
            bus.par_err     = vecs[v].perr;
            bus.stp_err     = vecs[v].serr;
            bus.rx_in       = 1'b0;
            dv = 0; fe = 0; dvn = 0; fen = 0; deser = 0; pc = 0;
            maxe = 0; maxb = 0; endc = 0; both = 0;
            for (int c = 1; c < 600; c++) begin
                @(negedge clk);
                if (c == 1) bus.rx_in = 1'b1;
                if (c == 20) bus.Prescale = 6'(vecs[v].mid_prescale);
                if (bus.deser_en) deser++;
                if (bus.par_chk_en) pc = 1;
                if (int'(bus.edge_cnt) > maxe) maxe = int'(bus.edge_cnt);
                if (int'(bus.bit_cnt) > maxb) maxb = int'(bus.bit_cnt);
                if (bus.data_valid) begin dvn++; if (dv == 0) dv = c; end
                if (bus.frame_err) begin fen++; if (fe == 0) fe = c; end
                if (bus.data_valid && bus.frame_err) both++;
                if (endc == 0 && !bus.busy) endc = c;
                else if (endc != 0) break;
            end
            check_int($sformatf("v%0d_end_cycle", v), endc, vecs[v].exp_end);
            check_int($sformatf("v%0d_dv_cycle", v), dv, vecs[v].exp_dv);
            check_int($sformatf("v%0d_fe_cycle", v), fe, vecs[v].exp_fe);
            check_int($sformatf("v%0d_dv_pulses", v), dvn, (vecs[v].exp_dv != 0) ? 1 : 0);
            check_int($sformatf("v%0d_fe_pulses", v), fen, (vecs[v].exp_fe != 0) ? 1 : 0);
            check_int($sformatf("v%0d_deser_cnt", v), deser, vecs[v].exp_deser);
            check_int($sformatf("v%0d_par_chk_seen", v), pc, int'(vecs[v].exp_parchk));
            check_int($sformatf("v%0d_max_edge", v), maxe, vecs[v].exp_max_edge);
            check_int($sformatf("v%0d_max_bit", v), maxb, vecs[v].exp_max_bit);
            check_int($sformatf("v%0d_dv_fe_overlap", v), both, 0);
            $display("vec %0d: ps=%0d par=%0d end=%0d dv=%0d fe=%0d deser=%0d max_edge=%0d",
                     v, vecs[v].prescale, vecs[v].par_en, endc, dv, fe, deser, maxe);
        end

        // Reset in the middle of DATA at bit_cnt == 3 clears everything at once.
        @(negedge clk);
        bus.Prescale = 6'd8; bus.par_en = 1'b1; bus.strt_glitch = 1'b0;
        bus.par_err = 1'b0; bus.stp_err = 1'b0; bus.rx_in = 1'b0;
        found = 0;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            if (c == 1) bus.rx_in = 1'b1;
            if (bus.bit_cnt == 4'd3 && bus.dat_samp_en && !bus.strt_chk_en) begin
                found = 1;
                break;
            end
        end
        check_int("reach_bit3", found, 1);
        #2 reset = 1'b1;
        #1 check_int("async_reset_outputs", all_outputs(), 0);
        $display("midframe reset: outputs=%0h", all_outputs());

        // Back-to-back frames with rx_in held low: pulses 89 cycles apart.
        @(negedge clk);
        reset = 1'b0;
        bus.rx_in = 1'b0;
        d1 = 0; d2 = 0; dvn = 0; fen = 0;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (bus.frame_err) fen++;
            if (bus.data_valid) begin
                dvn++;
                if (d1 == 0) d1 = c;
                else begin
                    d2 = c;
                    bus.rx_in = 1'b1;
                    break;
                end
            end
        end
        check_int("b2b_first_dv", d1, 89);
        check_int("b2b_spacing", d2 - d1, 89);
        check_int("b2b_dv_pulses", dvn, 2);
        check_int("b2b_frame_err", fen, 0);
        @(negedge clk);
        check_int("b2b_idle_busy", int'(bus.busy), 0);
        check_int("b2b_dv_single", int'(bus.data_valid), 0);
        $display("back-to-back: dv at %0d and %0d", d1, d2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
